// File: rtl/dl11_term_ctrl.sv
// DL11-style console terminal controller.
// Wishbone slave for RCSR/RBUF/XCSR/XBUF at 177560..177566. It buffers received bytes in a
// small FIFO, sequences the serial_tx handshake and raises vectored interrupt requests.
// Optional feature: define DL11_MAINT_LOOPBACK_EN for XCSR bit2 MAINT, which loops
// transmitted bytes back into the receive FIFO.
module dl11_term_ctrl #(
  parameter int unsigned FIFO_AW = 2,
  parameter logic [15:0] RX_VEC  = 16'o000060,
  parameter logic [15:0] TX_VEC  = 16'o000064
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [1:0]  wb_sel_i,
  output logic        wb_ack_o,
  output logic [7:0]  tx_data,
  output logic        tx_send,
  input  logic        tx_busy,
  input  logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic        rx_read,
  output logic        irq_req,
  output logic [15:0] irq_vec,
  input  logic        irq_ack
);

  localparam int unsigned Depth = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FullCnt = (FIFO_AW + 1)'(Depth);

  typedef enum logic [1:0] {StIdle, StSend, StWaitBusy, StWaitDone} tx_state_e;

  tx_state_e          state_q;
  logic               ack_q, rx_read_q, tx_send_q, rx_ie_q, tx_ie_q, tx_pend_q, ovr_q;
  logic [15:0]        dat_q;
  logic [7:0]         tx_data_q;
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q;
  logic [7:0]         mem_q [Depth];

  logic        maint;
  logic        acc, rd, wr, wr_rcsr, wr_xcsr, wr_xbuf, rd_rbuf, xbuf_acc;
  logic        ready, empty, full, rx_take, loop_push, push_req, push, pop, ovr_set;
  logic        tx_done, rx_req, tx_presented, pend_set, pend_clr;
  logic [7:0]  push_byte;
  logic [15:0] rdata;
  logic        unused_bits;

  assign unused_bits = ^{wb_dat_i[15:8], wb_dat_i[5:0], wb_sel_i[1], wb_adr_i[0]};

`ifdef DL11_MAINT_LOOPBACK_EN
  logic maint_q;
  assign maint     = maint_q;
  assign loop_push = maint_q & (state_q == StSend);
`else
  assign maint     = 1'b0;
  assign loop_push = 1'b0;
`endif

  // Bus decode: an access commits on the edge where ack rises.
  always_comb begin
    acc      = wb_cyc_i & wb_stb_i & ~ack_q;
    rd       = acc & ~wb_we_i;
    wr       = acc & wb_we_i & wb_sel_i[0];
    wr_rcsr  = wr & (wb_adr_i[2:1] == 2'd0);
    rd_rbuf  = rd & (wb_adr_i[2:1] == 2'd1);
    wr_xcsr  = wr & (wb_adr_i[2:1] == 2'd2);
    wr_xbuf  = wr & (wb_adr_i[2:1] == 2'd3);
    ready    = (state_q == StIdle);
    xbuf_acc = wr_xbuf & ready;
    empty    = (count_q == '0);
    full     = (count_q == FullCnt);
  end

  // FIFO push/pop and interrupt qualifiers.
  always_comb begin
    rx_take      = rx_ready & ~rx_read_q & ~maint;
    push_req     = rx_take | loop_push;
    push_byte    = loop_push ? tx_data_q : rx_data;
    push         = push_req & ~full;
    ovr_set      = push_req & full;
    pop          = rd_rbuf & ~empty;
    tx_done      = ((state_q == StWaitDone) & ~tx_busy) | ((state_q == StSend) & maint);
    rx_req       = rx_ie_q & ~empty;
    tx_presented = tx_pend_q & ~rx_req;
    pend_set     = (tx_done & tx_ie_q) | (wr_xcsr & wb_dat_i[6] & ~tx_ie_q & ready);
    pend_clr     = xbuf_acc | (wr_xcsr & ~wb_dat_i[6]) | (irq_ack & tx_presented);
  end

  // Register read mux, sampled into wb_dat_o on the acking edge.
  always_comb begin
    rdata = '0;
    unique case (wb_adr_i[2:1])
      2'd0: rdata = {8'h00, ~empty, rx_ie_q, 6'b000000};
      2'd1: rdata = {ovr_q, ovr_q, 6'b000000, empty ? 8'h00 : mem_q[rd_ptr_q]};
      2'd2: rdata = {8'h00, ready, tx_ie_q, 3'b000, maint, 2'b00};
      2'd3: rdata = '0;
    endcase
  end

  // FIFO storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_byte;
  end

  // Bus, FIFO bookkeeping, control bits and interrupt pending state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_q     <= 1'b0;
      dat_q     <= '0;
      rx_read_q <= 1'b0;
      rx_ie_q   <= 1'b0;
      tx_ie_q   <= 1'b0;
      tx_pend_q <= 1'b0;
      ovr_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
`ifdef DL11_MAINT_LOOPBACK_EN
      maint_q   <= 1'b0;
`endif
    end else begin
      ack_q     <= acc;
      dat_q     <= rd ? rdata : 16'h0000;
      rx_read_q <= rx_take;
      if (wr_rcsr) rx_ie_q <= wb_dat_i[6];
      if (wr_xcsr) tx_ie_q <= wb_dat_i[6];
`ifdef DL11_MAINT_LOOPBACK_EN
      if (wr_xcsr) maint_q <= wb_dat_i[2];
`endif
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
      // A new overrun wins over the clear from a concurrent RBUF read.
      if (ovr_set)      ovr_q <= 1'b1;
      else if (rd_rbuf) ovr_q <= 1'b0;
      // Clears take precedence so writing TX_IE=0 always silences the request.
      if (pend_clr)      tx_pend_q <= 1'b0;
      else if (pend_set) tx_pend_q <= 1'b1;
    end
  end

  // Transmit handshake FSM with registered tx_data / tx_send.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      tx_data_q <= '0;
      tx_send_q <= 1'b0;
    end else begin
      tx_send_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (xbuf_acc) begin
            tx_data_q <= wb_dat_i[7:0];
            tx_send_q <= ~maint;
            state_q   <= StSend;
          end
        end
        StSend:     state_q <= maint ? StIdle : StWaitBusy;
        StWaitBusy: if (tx_busy) state_q <= StWaitDone;
        StWaitDone: if (!tx_busy) state_q <= StIdle;
      endcase
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign tx_data  = tx_data_q;
  assign tx_send  = tx_send_q;
  assign rx_read  = rx_read_q;
  assign irq_req  = rx_req | tx_pend_q;
  assign irq_vec  = rx_req ? RX_VEC : (tx_pend_q ? TX_VEC : 16'h0000);

endmodule

// File: doc/dl11_term_ctrl.md
Name: dl11_term_ctrl

Overview:
- DL11-style console terminal controller: Wishbone slave at 177560..177566 that sequences the external serial_tx / serial_rx pair.
- Buffers received bytes in a small FIFO and runs the transmit handshake.
- Raises vectored interrupt requests toward the vm1_wb CPU.
- Replaces the ad-hoc status/data mux and ack logic at the FF7x decode in the top level.

Parameters:
FIFO_AW, 2, log2 of RX FIFO depth (depth 4)
RX_VEC, 16'o000060, vector presented for receiver interrupt
TX_VEC, 16'o000064, vector presented for transmitter interrupt

Ports:
clk  in  1  system clock (mclkp domain)
reset_n  in  1  asynchronous reset, active low
wb_adr_i  in  3  word/byte address within block, [2:1] selects register
wb_dat_i  in  16  write data
wb_dat_o  out  16  read data, zero when not acking
wb_cyc_i  in  1  cycle
wb_stb_i  in  1  strobe (already address-decoded)
wb_we_i  in  1  write enable
wb_sel_i  in  2  byte lanes
wb_ack_o  out  1  acknowledge
tx_data  out  8  byte to serial_tx
tx_send  out  1  one-cycle send pulse
tx_busy  in  1  serial_tx busy
rx_data  in  8  byte from serial_rx
rx_ready  in  1  serial_rx byte valid
rx_read  out  1  one-cycle pulse, consumes serial_rx byte
irq_req  out  1  vectored interrupt request
irq_vec  out  16  vector for current request
irq_ack  in  1  one-cycle interrupt acknowledge

Behaviour:
- Reset (async, reset_n=0): all outputs 0, FIFO empty, overrun=0, both IE=0, TX state IDLE, tx_pend=0.
- WB: wb_ack_o <= cyc & stb & !wb_ack_o, so it is a registered one-cycle pulse one clock after strobe. Back-to-back strobes ack every other cycle.
- Register side effects commit on the edge where ack rises. wb_dat_o is valid while ack=1.
- Writes honour wb_sel_i: only the low byte holds writable bits, so sel[0]=0 means no write effect.
- Reg 0 RCSR (177560): bit7 DONE = FIFO non-empty (RO); bit6 RX_IE (RW). Other bits read 0.
- Reg 1 RBUF (177562) read: bit15 ERR = overrun, bit14 OR = overrun, [7:0] = FIFO head. Reads 0 data if empty.
  - Read pops the head if non-empty and clears overrun. Writes are ignored.
- Reg 2 XCSR (177564): bit7 READY = (tx state IDLE) (RO); bit6 TX_IE (RW).
- Reg 3 XBUF (177566) write: accepted only when READY; otherwise silently dropped, still acked. Read returns 0.
- RX path: when rx_ready=1 and rx_read not pulsed last cycle:
  - Pulse rx_read for 1 cycle.
  - If FIFO not full, push rx_data; otherwise set overrun and drop the byte.
- Simultaneous push and pop: both happen and count is unchanged. A pop on empty is a no-op.
- FIFO pointers are FIFO_AW bits and wrap modulo depth. Count is FIFO_AW+1 bits; full when count == 2^FIFO_AW.
- TX FSM:
  - IDLE: accepted XBUF write latches tx_data = wb_dat_i[7:0], pulses tx_send, goes to SEND.
  - SEND: go to WAIT_BUSY.
  - WAIT_BUSY: stay until tx_busy=1, then go to WAIT_DONE.
  - WAIT_DONE: stay until tx_busy=0, then go to IDLE.
- tx_pend: set on the edge READY goes 0->1 while TX_IE=1, or when TX_IE is written 0->1 while READY. Cleared by an accepted XBUF write, by TX_IE write 0, or by irq_ack while the TX vector is presented.
- rx_req = RX_IE & DONE (level). irq_req = rx_req | tx_pend.
- irq_vec = RX_VEC if rx_req, else TX_VEC if tx_pend, else 0. RX has priority.
- irq_ack with rx presented has no state effect; the request persists until the FIFO drains.
- Reset mid-transfer aborts the FSM to IDLE. serial_tx completes its frame independently.

Optional Feature:
- Macro DL11_MAINT_LOOPBACK_EN enables XCSR bit2 MAINT (RW).
- With MAINT=1: tx_send is suppressed, and the FSM goes IDLE->SEND->IDLE in 2 cycles. The byte is pushed into the RX FIFO, subject to overrun rules. rx_ready is ignored and rx_read is not pulsed.
- Without the macro: bit2 reads 0, writes are ignored, and there is no loopback logic.

Test Plan:
- Reset then read RCSR/XCSR -> 16'o000000 / 16'o000200, irq_req=0.
- rx_ready with bytes 8'h41, 8'h42 -> rx_read pulses twice, RCSR=16'o200. RBUF reads 16'h0041 then 16'h0042, then RCSR=0.
- 5 RX bytes without reads (depth 4) -> 5th dropped. RBUF read = 16'hC000 | first byte, second read has bit15=0.
- Write XBUF 8'h55 -> tx_send pulse with tx_data=8'h55, READY=0. XBUF write 8'hAA while busy is ignored. tx_busy high 10 cycles then low -> READY=1.
- TX_IE=1 after completion -> irq_req=1, irq_vec=16'o64. Push an RX byte with RX_IE=1 -> irq_vec=16'o60. irq_ack on TX vector clears tx_pend.
- With DL11_MAINT_LOOPBACK_EN: set MAINT, write XBUF 8'h33 -> no tx_send, RBUF reads 16'h0033 within 4 cycles.
